// File: rtl/placar_jogo.sv
// Two-team scoreboard for a hand-series card game.
// Points accumulate per match up to TARGET. The first team to reach TARGET
// wins the match. The first team to win GAMES matches wins the game.
// Every output is a register that updates on the rising edge of Clk.
module placar_jogo #(
    parameter int W      = 5,
    parameter int TARGET = 12,
    parameter int GAMES  = 2,
    parameter int GW     = 2
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          Valid,
    input  logic          Team,
    input  logic [3:0]    Pts,
    input  logic          New_game,
    output logic [W-1:0]  Score0,
    output logic [W-1:0]  Score1,
    output logic [GW-1:0] Games0,
    output logic [GW-1:0] Games1,
    output logic          I,
    output logic          Win_team,
    output logic          Game_over,
    output logic          Err
);

    localparam logic [1:0] PLAY      = 2'd0;
    localparam logic [1:0] MATCH_END = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd2;

    localparam logic [W:0]    TGT    = (W+1)'(TARGET);
    localparam logic [GW-1:0] G_ONE  = GW'(1);
    localparam logic [GW-1:0] G_MAX  = GW'(GAMES);

    logic [1:0]    state;
    logic [W-1:0]  cur;
    logic [W:0]    sum;
    logic [GW-1:0] win_games;

    // The sum is one bit wider than the score, so it cannot wrap before the
    // saturation check against TARGET.
    always_comb begin
        cur       = Team ? Score1 : Score0;
        sum       = {1'b0, cur} + {{(W-3){1'b0}}, Pts};
        win_games = Win_team ? Games1 : Games0;
    end

    // Scoreboard state machine. Clr has priority over every other input.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state     <= PLAY;
            Score0    <= '0;
            Score1    <= '0;
            Games0    <= '0;
            Games1    <= '0;
            I         <= 1'b0;
            Win_team  <= 1'b0;
            Game_over <= 1'b0;
            Err       <= 1'b0;
        end else begin
            I   <= 1'b0;
            Err <= 1'b0;
            case (state)
                PLAY: begin
                    if (Valid && Pts != 4'd0) begin
                        if (sum >= TGT) begin
                            // Winning award: the score shows TARGET for one cycle
                            // and the match count increments on the same edge.
                            if (Team) begin
                                Score1 <= TGT[W-1:0];
                                Games1 <= Games1 + G_ONE;
                            end else begin
                                Score0 <= TGT[W-1:0];
                                Games0 <= Games0 + G_ONE;
                            end
                            Win_team <= Team;
                            I        <= 1'b1;
                            state    <= MATCH_END;
                        end else if (Team) begin
                            Score1 <= sum[W-1:0];
                        end else begin
                            Score0 <= sum[W-1:0];
                        end
                    end
                end
                MATCH_END: begin
                    // Any award that arrives in this cycle is dropped.
                    Score0 <= '0;
                    Score1 <= '0;
                    Err    <= Valid;
                    if (win_games == G_MAX) begin
                        state     <= GAME_OVER;
                        Game_over <= 1'b1;
                    end else begin
                        state <= PLAY;
                    end
                end
                GAME_OVER: begin
                    Err <= Valid;
                    if (New_game) begin
                        Games0    <= '0;
                        Games1    <= '0;
                        Game_over <= 1'b0;
                        state     <= PLAY;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_placar_jogo.sv
// Testbench for placar_jogo.
// It applies a table of directed vectors, then runs a long random sequence.
// The random sequence is checked against a score-rule model written with
// integer arrays.
module tb_placar_jogo;

    localparam int W = 5, TARGET = 12, GAMES = 2, GW = 2;

    logic          Clk = 0;
    logic          Clr = 0, Valid = 0, Team = 0, New_game = 0;
    logic [3:0]    Pts = 0;
    logic [W-1:0]  Score0, Score1;
    logic [GW-1:0] Games0, Games1;
    logic          I, Win_team, Game_over, Err;

    int n_tests = 0;
    int n_fail  = 0;

    placar_jogo #(.W(W), .TARGET(TARGET), .GAMES(GAMES), .GW(GW)) dut (
        .Clk(Clk), .Clr(Clr), .Valid(Valid), .Team(Team), .Pts(Pts),
        .New_game(New_game), .Score0(Score0), .Score1(Score1),
        .Games0(Games0), .Games1(Games1), .I(I), .Win_team(Win_team),
        .Game_over(Game_over), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic clr, valid, team, ng;
        int   pts;
        int   s0, s1, g0, g1, i, wt, go, err;
    } vec_t;

    vec_t vecs[20];

    // Compares one field and counts it.
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compares every output against the expected values for one cycle.
    task automatic chk_all(input string tag, input int s0, input int s1, input int g0,
                           input int g1, input int i, input int wt, input int go, input int err);
        chk({tag, ".Score0"},    int'(Score0),    s0);
        chk({tag, ".Score1"},    int'(Score1),    s1);
        chk({tag, ".Games0"},    int'(Games0),    g0);
        chk({tag, ".Games1"},    int'(Games1),    g1);
        chk({tag, ".I"},         int'(I),         i);
        chk({tag, ".Win_team"},  int'(Win_team),  wt);
        chk({tag, ".Game_over"}, int'(Game_over), go);
        chk({tag, ".Err"},       int'(Err),       err);
    endtask

    // Drives one cycle of inputs, then waits until just after the edge.
    task automatic step(input logic clr, input logic valid, input logic team,
                        input int pts, input logic ng);
        Clr = clr; Valid = valid; Team = team; Pts = 4'(pts); New_game = ng;
        @(posedge Clk);
        #1;
    endtask

    // Model state: phase 0 = playing, 1 = match just won, 2 = game over.
    int m_s[2], m_g[2], m_wt, m_ph, m_i, m_err;

    task automatic model_step(input logic clr, input logic valid, input logic team,
                              input int pts, input logic ng);
        int t;
        t = int'(team);
        m_i = 0; m_err = 0;
        if (clr) begin
            m_s[0] = 0; m_s[1] = 0; m_g[0] = 0; m_g[1] = 0; m_wt = 0; m_ph = 0;
        end else if (m_ph == 0) begin
            if (valid && pts > 0) begin
                if (m_s[t] + pts >= TARGET) begin
                    m_s[t] = TARGET; m_g[t]++; m_wt = t; m_i = 1; m_ph = 1;
                end else begin
                    m_s[t] = m_s[t] + pts;
                end
            end
        end else if (m_ph == 1) begin
            m_s[0] = 0; m_s[1] = 0;
            m_err = int'(valid);
            m_ph = (m_g[m_wt] >= GAMES) ? 2 : 0;
        end else begin
            m_err = int'(valid);
            if (ng) begin
                m_g[0] = 0; m_g[1] = 0; m_ph = 0;
            end
        end
    endtask

    initial begin
        //           clr valid team ng  pts  s0 s1 g0 g1 i wt go err
        vecs[0]  = '{1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0,  3,   3, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0,  1,   3, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0,  6,   9, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0,  0,   9, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0,  6,  12, 1, 1, 0, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,  0,   0, 0, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 1, 0, 15,   0,12, 1, 1, 1, 1, 0, 0};
        vecs[8]  = '{0, 1, 1, 0,  5,   0, 0, 1, 1, 0, 1, 0, 1};
        vecs[9]  = '{0, 1, 1, 0, 11,   0,11, 1, 1, 0, 1, 0, 0};
        vecs[10] = '{0, 1, 1, 0, 12,   0,12, 1, 2, 1, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0,  0,   0, 0, 1, 2, 0, 1, 1, 0};
        vecs[12] = '{0, 1, 0, 0,  3,   0, 0, 1, 2, 0, 1, 1, 1};
        vecs[13] = '{0, 0, 0, 0,  0,   0, 0, 1, 2, 0, 1, 1, 0};
        vecs[14] = '{0, 1, 0, 1,  3,   0, 0, 0, 0, 0, 1, 0, 1};
        vecs[15] = '{0, 1, 1, 0, 11,   0,11, 0, 0, 0, 1, 0, 0};
        vecs[16] = '{1, 1, 1, 0, 12,   0, 0, 0, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 1, 0, 1,  4,   4, 0, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 0, 0,  8,  12, 0, 1, 0, 1, 0, 0, 0};
        vecs[19] = '{1, 1, 1, 1,  5,   0, 0, 0, 0, 0, 0, 0, 0};

        for (int k = 0; k < 20; k++) begin
            step(vecs[k].clr, vecs[k].valid, vecs[k].team, vecs[k].pts, vecs[k].ng);
            chk_all($sformatf("vec%0d", k), vecs[k].s0, vecs[k].s1, vecs[k].g0, vecs[k].g1,
                    vecs[k].i, vecs[k].wt, vecs[k].go, vecs[k].err);
        end

        // Sequence: the award that arrives during a match end is lost.
        // The next match starts from 0-0.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 15, 0);
        chk_all("seq_win", 0, 12, 0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 15, 0);
        chk_all("seq_drop", 0, 0, 0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 2, 0);
        chk_all("seq_fresh", 2, 0, 0, 1, 0, 1, 0, 0);

        // Random run checked against the model.
        step(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r_clr, r_v, r_t, r_ng;
            int   r_p;
            r_clr = ($urandom_range(0, 99) == 0);
            r_v   = ($urandom_range(0, 2) != 0);
            r_t   = 1'($urandom_range(0, 1));
            r_p   = int'($urandom_range(0, 15));
            r_ng  = ($urandom_range(0, 7) == 0);
            step(r_clr, r_v, r_t, r_p, r_ng);
            model_step(r_clr, r_v, r_t, r_p, r_ng);
            chk_all($sformatf("rnd%0d", c), m_s[0], m_s[1], m_g[0], m_g[1],
                    m_i, m_wt, (m_ph == 2) ? 1 : 0, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/placar_jogo.md
PLACAR_JOGO -- requirements
Module: placar_jogo

Interface
REQ-001 Parameter W, default 5: score accumulator width in bits; W SHALL satisfy 2^W > TARGET+12.
REQ-002 Parameter TARGET, default 12: points that win a match (hand series).
REQ-003 Parameter GAMES, default 2: match wins needed to win the game (best of 2*GAMES-1).
REQ-004 Parameter GW, default 2: match-counter width; 2^GW > GAMES.
REQ-005 Clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Clr  input  1  reset, synchronous, active-high.
REQ-007 Valid  input  1  point-award strobe, one award per cycle it is high.
REQ-008 Team  input  1  team receiving the award (0 or 1), sampled with Valid.
REQ-009 Pts  input  4  points awarded (0..15), sampled with Valid.
REQ-010 New_game  input  1  restarts the game from GAME_OVER.
REQ-011 Score0, Score1  output  W  current match score of team 0 / team 1.
REQ-012 Games0, Games1  output  GW  matches won by team 0 / team 1.
REQ-013 I  output  1  one-cycle pulse: a match has just been won.
REQ-014 Win_team  output  1  team that won the last match; held until next match win.
REQ-015 Game_over  output  1  high while in GAME_OVER.
REQ-016 Err  output  1  one-cycle pulse: an award was dropped.

Function
REQ-017 FSM states SHALL be PLAY, MATCH_END, GAME_OVER; all outputs registered.
REQ-018 PLAY, Valid=1: Score[Team] <= min(Score[Team]+Pts, TARGET) on the next edge; the other score unchanged; sum computed at W+1 bits, no wrap.
REQ-019 PLAY, Valid=1, Pts=0: no state or score change, no Err.
REQ-020 PLAY, award with Score[Team]+Pts >= TARGET: next state MATCH_END; Score[Team] shows TARGET; Win_team <= Team; Games[Team] increments in the same edge.
REQ-021 MATCH_END lasts exactly one cycle: I=1, then both scores cleared to 0 on the following edge.
REQ-022 MATCH_END exit: to GAME_OVER if Games[Win_team] = GAMES, else to PLAY.
REQ-023 Valid=1 in MATCH_END or GAME_OVER SHALL be dropped with Err=1 for one cycle and no score change.
REQ-024 GAME_OVER: Game_over=1; scores hold 0; Games and Win_team hold; exit only by Clr or New_game.
REQ-025 New_game in GAME_OVER: next edge clears scores and Games, Game_over=0, state PLAY; Valid in the same cycle is dropped (Err=1).
REQ-026 New_game outside GAME_OVER SHALL be ignored.
REQ-027 Latency: award at edge k visible on ScoreX after edge k; I high during cycle after edge k when the award wins.
REQ-028 Games counters SHALL never exceed GAMES.

Reset
REQ-029 Clr=1 at an edge: state PLAY, Score0=Score1=0, Games0=Games1=0, I=0, Win_team=0, Game_over=0, Err=0.
REQ-030 Clr SHALL override Valid and New_game in the same cycle, in any state including MATCH_END.
REQ-031 Outputs before first Clr are undefined; bench SHALL apply Clr first.

Verification
REQ-032 Clr; awards T0:3, T1:1, T0:6 -> Score0=9, Score1=1, I=0, Games0=0.
REQ-033 From Score0=9, award T0:6 -> Score0=12 for one cycle, I=1, Win_team=0, Games0=1; next cycle Score0=Score1=0, state PLAY.
REQ-034 Team 1 wins two matches (TARGET=12, GAMES=2) -> Games1=2, Game_over=1; Valid T0:3 then -> Err=1, Score0=0.
REQ-035 In GAME_OVER, New_game=1 with Valid=1 -> next cycle Game_over=0, Games0=Games1=0, Err=1, scores 0.
REQ-036 Score1=11, Valid T1:12 with Clr=1 same cycle -> all outputs reset values, I stays 0.
REQ-037 Valid held high during MATCH_END cycle -> Err=1 that cycle, award lost, new match starts at 0-0.
